spi_access_arbiter: RTL and testbench

- Sits between two independent register-access requesters (e.g. PS config path, PL init sequencer) and a single spi_master instance.
- Arbitrates round-robin, issues one spi_wr_cmd/spi_rd_cmd pulse per granted transaction, and tracks spi_busy to completion.
- Returns read data and completion status to the winning requester, then enforces a minimum inter-transaction gap before the next grant.

---
 rtl/spi_access_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_spi_access_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_access_arbiter.sv
// spi_access_arbiter: round-robin arbiter between two register-access
// requesters and one spi_master. Grants one transaction at a time, issues a
// single wr/rd command pulse, tracks spi_busy to completion (with a timeout on
// busy rising), returns status/read data, then holds off for an idle gap.
//
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   req_valid/req_rd[1:0]   per-requester request and type (1 = read)
//   req_wdata[2*MOSI_W]     per-requester word, requester i at [i*MOSI_W +: MOSI_W]
//   req_ready/done/err[1:0] accept pulse, completion pulse, timeout flag
//   req_rdata[MISO_W]       last captured read data
//   spi_wr_cmd/spi_rd_cmd   command pulses to spi_master
//   mosi_data[MOSI_W]       latched word for spi_master
//   spi_busy, miso_data     spi_master status and read data
module spi_access_arbiter #(
    parameter int unsigned MOSI_W       = 32,
    parameter int unsigned MISO_W       = 8,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_rd,
    input  logic [2*MOSI_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            req_done,
    output logic [1:0]            req_err,
    output logic [MISO_W-1:0]     req_rdata,
    output logic                  spi_wr_cmd,
    output logic                  spi_rd_cmd,
    output logic [MOSI_W-1:0]     mosi_data,
    input  logic                  spi_busy,
    input  logic [MISO_W-1:0]     miso_data
);

    // Counters hold at most BUSY_TIMEOUT-1 and GAP_CYCLES-1.
    localparam int unsigned TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4,
        GAP     = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                rd_q, rd_d;
    logic                err_q, err_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [MOSI_W-1:0]   mosi_q, mosi_d;
    logic [MISO_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          ready_q, ready_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          err_out_q, err_out_d;
    logic                wr_cmd_q, wr_cmd_d;
    logic                rd_cmd_q, rd_cmd_d;

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            rr_ptr_q  <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            mosi_q    <= '0;
            rdata_q   <= '0;
            ready_q   <= '0;
            done_q    <= '0;
            err_out_q <= '0;
            wr_cmd_q  <= 1'b0;
            rd_cmd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            rr_ptr_q  <= rr_ptr_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            mosi_q    <= mosi_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_out_q <= err_out_d;
            wr_cmd_q  <= wr_cmd_d;
            rd_cmd_q  <= rd_cmd_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rd_d      = rd_q;
        err_d     = err_q;
        rr_ptr_d  = rr_ptr_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        mosi_d    = mosi_q;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (!spi_busy && (req_valid != 2'b00)) begin
                    // Pointer holder wins if valid, otherwise the other side.
                    gnt_d   = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
                    rd_d    = req_rd[gnt_d];
                    mosi_d  = gnt_d ? req_wdata[MOSI_W +: MOSI_W] : req_wdata[0 +: MOSI_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_d = '0;
                err_d    = 1'b0;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                // Busy rising is checked first so it beats a coincident timeout.
                if (spi_busy) begin
                    state_d = WAIT_LO;
                end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!spi_busy) begin
                    if (rd_q) begin
                        rdata_d = miso_data;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_ptr_d  = ~gnt_q;
                gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                state_d   = GAP;
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so pulses line up with ISSUE/DONE.
    always_comb begin
        ready_d   = '0;
        done_d    = '0;
        err_out_d = '0;
        wr_cmd_d  = 1'b0;
        rd_cmd_d  = 1'b0;
        if (state_d == ISSUE) begin
            ready_d  = {gnt_d, ~gnt_d};
            wr_cmd_d = ~rd_d;
            rd_cmd_d = rd_d;
        end
        if (state_d == DONE) begin
            done_d    = {gnt_d, ~gnt_d};
            err_out_d = err_d ? {gnt_d, ~gnt_d} : 2'b00;
        end
    end

    assign req_ready  = ready_q;
    assign req_done   = done_q;
    assign req_err    = err_out_q;
    assign req_rdata  = rdata_q;
    assign spi_wr_cmd = wr_cmd_q;
    assign spi_rd_cmd = rd_cmd_q;
    assign mosi_data  = mosi_q;

endmodule

// File: tb/tb_spi_access_arbiter.sv
// Directed self-checking bench for spi_access_arbiter; the bench plays the
// role of both requesters and of spi_master (driving spi_busy/miso_data).
module tb_spi_access_arbiter;

    localparam int unsigned MOSI_W       = 32;
    localparam int unsigned MISO_W       = 8;
    localparam int unsigned GAP_CYCLES   = 16;
    localparam int unsigned BUSY_TIMEOUT = 64;

    logic                sys_clk = 1'b0;
    logic                sys_rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_rd;
    logic [2*MOSI_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          req_done;
    logic [1:0]          req_err;
    logic [MISO_W-1:0]   req_rdata;
    logic                spi_wr_cmd;
    logic                spi_rd_cmd;
    logic [MOSI_W-1:0]   mosi_data;
    logic                spi_busy;
    logic [MISO_W-1:0]   miso_data;

    int vec  = 0;
    int errs = 0;

    spi_access_arbiter #(
        .MOSI_W      (MOSI_W),
        .MISO_W      (MISO_W),
        .GAP_CYCLES  (GAP_CYCLES),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .spi_wr_cmd(spi_wr_cmd),
        .spi_rd_cmd(spi_rd_cmd),
        .mosi_data (mosi_data),
        .spi_busy  (spi_busy),
        .miso_data (miso_data)
    );

    always #5 sys_clk = ~sys_clk;

    // Step negedges until req_ready is seen or the bound expires.
    task automatic wait_ready(input int bound, output int cyc);
        cyc = 0;
        do begin
            @(negedge sys_clk);
            cyc++;
        end while (req_ready == 2'b00 && cyc < bound);
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        do begin
            @(negedge sys_clk);
            cyc++;
        end while (req_done == 2'b00 && cyc < bound);
    endtask

    // spi_master stand-in: busy high for 'hold' cycles, then data and busy low.
    task automatic serve(input int hold, input logic [MISO_W-1:0] miso);
        spi_busy = 1'b1;
        repeat (hold) @(negedge sys_clk);
        miso_data = miso;
        spi_busy  = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; req_valid = '0; req_rd = '0; req_wdata = '0;
        spi_busy = 1'b0; miso_data = '0;
        repeat (3) @(negedge sys_clk);
        vec++;
        if ({req_ready, req_done, req_err, spi_wr_cmd, spi_rd_cmd} !== 8'h00) begin
            errs++; $display("FAIL reset_ctrl: got %b want 00000000",
                             {req_ready, req_done, req_err, spi_wr_cmd, spi_rd_cmd});
        end
        vec++;
        if ({mosi_data, req_rdata} !== 40'h0) begin
            errs++; $display("FAIL reset_data: got %h want 0", {mosi_data, req_rdata});
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_write_req0();
        int pulses;
        int cyc;
        req_valid = 2'b01; req_rd = 2'b00;
        req_wdata = {32'h11111111, 32'h00A5CDEF};
        wait_ready(5, cyc);
        vec++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL wr_ready: got %b want 01", req_ready); end
        vec++;
        if ({spi_wr_cmd, spi_rd_cmd} !== 2'b10) begin
            errs++; $display("FAIL wr_cmd: got %b want 10", {spi_wr_cmd, spi_rd_cmd});
        end
        vec++;
        if (mosi_data !== 32'h00A5CDEF) begin errs++; $display("FAIL wr_mosi: got %h want 00a5cdef", mosi_data); end
        req_valid = 2'b00;
        spi_busy  = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge sys_clk);
            if (spi_wr_cmd || spi_rd_cmd || req_ready != 2'b00 || req_done != 2'b00) pulses++;
        end
        vec++;
        if (mosi_data !== 32'h00A5CDEF) begin errs++; $display("FAIL wr_mosi_hold: got %h want 00a5cdef", mosi_data); end
        miso_data = 8'hFF;
        spi_busy  = 1'b0;
        @(negedge sys_clk);
        vec++;
        if (pulses !== 0) begin errs++; $display("FAIL wr_extra_pulses: got %0d want 0", pulses); end
        vec++;
        if ({req_done, req_err} !== 4'b0100) begin
            errs++; $display("FAIL wr_done: got done=%b err=%b want 01/00", req_done, req_err);
        end
        vec++;
        if (req_rdata !== 8'h00) begin errs++; $display("FAIL wr_rdata: got %h want 00", req_rdata); end
        @(negedge sys_clk);
        vec++;
        if (req_done !== 2'b00) begin errs++; $display("FAIL wr_done_pulse: got %b want 00", req_done); end
    endtask

    task automatic test_read_req1();
        int cyc;
        req_valid = 2'b10; req_rd = 2'b10;
        req_wdata[63:32] = 32'h00A5ABCD;
        wait_ready(40, cyc);
        vec++;
        if (req_ready !== 2'b10) begin errs++; $display("FAIL rd_ready: got %b want 10", req_ready); end
        vec++;
        if ({spi_wr_cmd, spi_rd_cmd} !== 2'b01) begin
            errs++; $display("FAIL rd_cmd: got %b want 01", {spi_wr_cmd, spi_rd_cmd});
        end
        vec++;
        if (mosi_data !== 32'h00A5ABCD) begin errs++; $display("FAIL rd_mosi: got %h want 00a5abcd", mosi_data); end
        req_valid = 2'b00;
        serve(3, 8'h3C);
        wait_done(5, cyc);
        vec++;
        if ({req_done, req_err} !== 4'b1000) begin
            errs++; $display("FAIL rd_done: got done=%b err=%b want 10/00", req_done, req_err);
        end
        vec++;
        if (req_rdata !== 8'h3C) begin errs++; $display("FAIL rd_rdata: got %h want 3c", req_rdata); end
        miso_data = 8'h00;
    endtask

    task automatic test_rdata_hold();
        int cyc;
        req_valid = 2'b01; req_rd = 2'b00;
        req_wdata[31:0] = 32'h12345678;
        wait_ready(40, cyc);
        vec++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL hold_ready: got %b want 01", req_ready); end
        req_valid = 2'b00;
        serve(3, 8'hEE);
        wait_done(5, cyc);
        vec++;
        if (req_done !== 2'b01) begin errs++; $display("FAIL hold_done: got %b want 01", req_done); end
        vec++;
        if (req_rdata !== 8'h3C) begin errs++; $display("FAIL hold_rdata: got %h want 3c", req_rdata); end
    endtask

    task automatic test_contention();
        int cyc;
        logic [1:0]        exp_g;
        logic [MOSI_W-1:0] exp_w;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        req_valid = 2'b11; req_rd = 2'b00;
        req_wdata = {32'hBBBB1111, 32'hAAAA0000};
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_w = (k % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB1111;
            wait_ready(60, cyc);
            vec++;
            if (req_ready !== exp_g) begin errs++; $display("FAIL cont_grant%0d: got %b want %b", k, req_ready, exp_g); end
            vec++;
            if (mosi_data !== exp_w) begin errs++; $display("FAIL cont_mosi%0d: got %h want %h", k, mosi_data, exp_w); end
            if (k > 0) begin
                vec++;
                if (cyc !== int'(GAP_CYCLES) + 2) begin
                    errs++; $display("FAIL cont_spacing%0d: got %0d want %0d", k, cyc, GAP_CYCLES + 2);
                end
            end
            if (k == 3) req_valid = 2'b00;
            serve(3, 8'h00);
            wait_done(5, cyc);
            vec++;
            if (req_done !== exp_g) begin errs++; $display("FAIL cont_done%0d: got %b want %b", k, req_done, exp_g); end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        req_valid = 2'b01; req_rd = 2'b00;
        req_wdata[31:0] = 32'hDEAD0001;
        wait_ready(40, cyc);
        vec++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL to_ready: got %b want 01", req_ready); end
        req_valid = 2'b00;
        wait_done(BUSY_TIMEOUT + 20, cyc);
        vec++;
        if (cyc !== int'(BUSY_TIMEOUT) + 1) begin
            errs++; $display("FAIL to_latency: got %0d want %0d", cyc, BUSY_TIMEOUT + 1);
        end
        vec++;
        if ({req_done, req_err} !== 4'b0101) begin
            errs++; $display("FAIL to_done: got done=%b err=%b want 01/01", req_done, req_err);
        end
        @(negedge sys_clk);
        vec++;
        if (req_err !== 2'b00) begin errs++; $display("FAIL to_err_pulse: got %b want 00", req_err); end
        // Next request must be served normally.
        req_valid = 2'b10; req_rd = 2'b10;
        req_wdata[63:32] = 32'h00000042;
        wait_ready(40, cyc);
        vec++;
        if (req_ready !== 2'b10) begin errs++; $display("FAIL to_next_ready: got %b want 10", req_ready); end
        req_valid = 2'b00;
        serve(3, 8'h5A);
        wait_done(5, cyc);
        vec++;
        if ({req_done, req_err, req_rdata} !== 12'b10_00_01011010) begin
            errs++; $display("FAIL to_next_done: got done=%b err=%b rdata=%h want 10/00/5a",
                             req_done, req_err, req_rdata);
        end
    endtask

    task automatic test_timeout_race();
        int cyc;
        req_valid = 2'b01; req_rd = 2'b00;
        req_wdata[31:0] = 32'h0000BEEF;
        wait_ready(40, cyc);
        vec++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL race_ready: got %b want 01", req_ready); end
        req_valid = 2'b00;
        // Busy sampled high in the last WAIT_HI cycle, coinciding with the timeout.
        repeat (BUSY_TIMEOUT) @(negedge sys_clk);
        spi_busy = 1'b1;
        @(negedge sys_clk);
        vec++;
        if (req_done !== 2'b00) begin errs++; $display("FAIL race_no_timeout: got %b want 00", req_done); end
        @(negedge sys_clk);
        spi_busy = 1'b0;
        wait_done(5, cyc);
        vec++;
        if ({req_done, req_err} !== 4'b0100) begin
            errs++; $display("FAIL race_done: got done=%b err=%b want 01/00", req_done, req_err);
        end
    endtask

    task automatic test_busy_at_start();
        int cyc;
        int seen;
        spi_busy  = 1'b1;
        req_valid = 2'b01; req_rd = 2'b00;
        req_wdata[31:0] = 32'hCAFE0000;
        seen = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (req_ready != 2'b00 || spi_wr_cmd || spi_rd_cmd) seen++;
        end
        vec++;
        if (seen !== 0) begin errs++; $display("FAIL busy_blocked: got %0d grants want 0", seen); end
        spi_busy = 1'b0;
        wait_ready(5, cyc);
        vec++;
        if (cyc !== 1 || req_ready !== 2'b01) begin
            errs++; $display("FAIL busy_release: got cyc=%0d ready=%b want 1/01", cyc, req_ready);
        end
        req_valid = 2'b00;
        serve(3, 8'h00);
        wait_done(5, cyc);
        vec++;
        if (req_done !== 2'b01) begin errs++; $display("FAIL busy_done: got %b want 01", req_done); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        repeat (20) @(negedge sys_clk);
        req_valid = 2'b10; req_rd = 2'b00;
        req_wdata[63:32] = 32'h55AA55AA;
        wait_ready(10, cyc);
        vec++;
        if (req_ready !== 2'b10) begin errs++; $display("FAIL rst_ready: got %b want 10", req_ready); end
        req_valid = 2'b00;
        spi_busy  = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        vec++;
        if ({req_ready, req_done, req_err, spi_wr_cmd, spi_rd_cmd} !== 8'h00) begin
            errs++; $display("FAIL rst_mid_ctrl: got %b want 00000000",
                             {req_ready, req_done, req_err, spi_wr_cmd, spi_rd_cmd});
        end
        vec++;
        if ({mosi_data, req_rdata} !== 40'h0) begin
            errs++; $display("FAIL rst_mid_data: got %h want 0", {mosi_data, req_rdata});
        end
        sys_rst  = 1'b0;
        spi_busy = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (req_done != 2'b00) seen++;
        end
        vec++;
        if (seen !== 0) begin errs++; $display("FAIL rst_no_done: got %0d want 0", seen); end
        // rr_ptr was 1 before reset; contention must now go to requester 0.
        req_valid = 2'b11;
        wait_ready(5, cyc);
        vec++;
        if (req_ready !== 2'b01) begin errs++; $display("FAIL rst_rr_ptr: got %b want 01", req_ready); end
        req_valid = 2'b00;
        serve(3, 8'h00);
        wait_done(5, cyc);
        vec++;
        if (req_done !== 2'b01) begin errs++; $display("FAIL rst_after_done: got %b want 01", req_done); end
    endtask

    initial begin
        test_reset();
        test_write_req0();
        test_read_req1();
        test_rdata_hold();
        test_contention();
        test_timeout();
        test_timeout_race();
        test_busy_at_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
